mod_down_counter_timer: RTL and testbench
=========================================

# mod_down_counter_timer

Programmable down-counting timer: the counterpart of the up-counting mod counter with runtime terminal value. Counts from FINAL_VALUE down to 0 and raises a single-cycle tick at terminal count. Operates in one-shot or periodic (auto-reload) mode. Sits beside the up counters as a baud/timeout/PWM-period generator; tick feeds enables of downstream logic.

## Interface
- BITS, 4, width of count and FINAL_VALUE
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- enable  input  1  count qualifier; when low, Q and state freeze
- start  input  1  load FINAL_VALUE and begin counting (also restarts while running)
- stop  input  1  abort; return to IDLE with Q = 0
- periodic  input  1  1 = reload at terminal count, 0 = one-shot
- FINAL_VALUE  input  BITS  reload value, sampled on start and on each periodic reload
- Q  output  BITS  current count (registered)
- tick  output  1  terminal-count pulse (combinational from registered state)
- busy  output  1  high while in RUN

## Operation
- States: IDLE, RUN. Reset -> IDLE, Q = 0, tick = 0, busy = 0.
- Priority per edge, highest first: reset, stop, start, enable-qualified counting.
- IDLE:
  - start = 1 -> Q <= FINAL_VALUE, state <= RUN.
  - Otherwise hold Q.
  - enable is not required for start.
- RUN, stop = 1 -> state <= IDLE, Q <= 0; tick forced 0 that cycle.
- RUN, start = 1 (stop = 0) -> Q <= FINAL_VALUE, stay RUN; tick forced 0 that cycle.
- RUN, enable = 1, Q != 0 -> Q <= Q - 1.
- RUN, enable = 1, Q == 0 -> tick = 1 this cycle, then:
  - periodic = 1 -> Q <= FINAL_VALUE, stay RUN.
  - periodic = 0 -> state <= IDLE, Q stays 0.
- RUN, enable = 0 -> hold Q and state; tick = 0.
- tick = (state == RUN) & enable & (Q == 0) & ~stop & ~start.
- busy = (state == RUN).
- Arithmetic: BITS-wide unsigned. Decrement never wraps below 0, because terminal count is handled before decrement.
- FINAL_VALUE = 0: periodic mode ticks on every enabled cycle; one-shot ticks once on the first enabled cycle after start.
- FINAL_VALUE changes mid-count have no effect until the next load.

## Timing
- Period in periodic mode = FINAL_VALUE + 1 enabled cycles between ticks, matching the sequence length of the up mod counter.
- Latency start -> first tick = FINAL_VALUE + 1 enabled cycles after the start edge.
- tick is high in the same cycle Q reads 0; the reload or IDLE transition takes effect on that cycle's edge.
- Reset asserted mid-count: Q, state and busy clear immediately (asynchronous), not waiting for clk; tick drops in the same instant. First valid start is sampled on the first rising edge after reset deasserts.
- No combinational path from FINAL_VALUE or periodic to any output.

## Structure
- Shared package mod_counter_pkg holds:
  - state typedef (IDLE = 1'b0, RUN = 1'b1)
  - default BITS constant, shared with the up counters
- Sub-module mod_down_counter_core: loadable BITS-wide down counter with ports clk, reset, load, load_value, dec, Q, zero.
- Top level holds the FSM, priority logic and tick/busy decode, and instantiates one core.

## Test plan
- Reset: reset = 1 mid-count with Q = 5 -> Q = 0, busy = 0, tick = 0 without a clock edge. After release, no activity until start.
- One-shot, BITS = 4, FINAL_VALUE = 3, periodic = 0, enable = 1, start pulse -> Q = 3, 2, 1, 0. tick high exactly in the Q = 0 cycle, then busy = 0 and Q holds 0.
- Periodic, FINAL_VALUE = 15 -> Q = 15..0 repeating, tick every 16 cycles. Changing FINAL_VALUE to 2 mid-count -> next period 3 cycles after the reload.
- Enable gating: FINAL_VALUE = 4, enable toggling 1010... -> Q decrements only on enabled edges; tick after 5 enabled cycles (10 clocks).
- Stop/start collisions:
  - stop and start together in RUN -> IDLE, Q = 0.
  - start at Q = 0 in RUN -> reload, no tick.
  - stop at Q = 0 -> no tick.
- FINAL_VALUE = 0, periodic = 1 -> tick every enabled cycle, Q constant 0, busy = 1.

Source files
------------

// File: rtl/mod_counter_pkg.sv
// Shared definitions for the mod counter family (up counters and the down-counting timer).
package mod_counter_pkg;

    localparam int DEFAULT_BITS = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/mod_down_counter_core.sv
// Loadable down counter; load takes precedence over decrement, zero flags a terminal count.
module mod_down_counter_core
    import mod_counter_pkg::*;
#(
    parameter int BITS = DEFAULT_BITS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [BITS-1:0] load_value,
    input  logic            dec,
    output logic [BITS-1:0] Q,
    output logic            zero
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Q <= '0;
        end else if (load) begin
            Q <= load_value;
        end else if (dec) begin
            Q <= Q - 1'b1;
        end
    end

    assign zero = (Q == '0);

endmodule

// File: rtl/mod_down_counter_timer.sv
// Programmable down-counting timer with one-shot or auto-reload operation and a terminal-count tick.
module mod_down_counter_timer
    import mod_counter_pkg::*;
#(
    parameter int BITS = DEFAULT_BITS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            start,
    input  logic            stop,
    input  logic            periodic,
    input  logic [BITS-1:0] FINAL_VALUE,
    output logic [BITS-1:0] Q,
    output logic            tick,
    output logic            busy
);

    state_t          state, state_next;
    logic            load;
    logic [BITS-1:0] load_value;
    logic            dec;
    logic            zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Stop clears the count by loading zero, so IDLE always presents Q = 0.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        load_value = FINAL_VALUE;
        dec        = 1'b0;
        if (stop) begin
            load       = 1'b1;
            load_value = '0;
            state_next = IDLE;
        end else if (start) begin
            load       = 1'b1;
            state_next = RUN;
        end else if (state == RUN && enable) begin
            if (zero) begin
                if (periodic) begin
                    load = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end else begin
                dec = 1'b1;
            end
        end
    end

    assign tick = (state == RUN) & enable & zero & ~stop & ~start;
    assign busy = (state == RUN);

    mod_down_counter_core #(
        .BITS(BITS)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_value(load_value),
        .dec       (dec),
        .Q         (Q),
        .zero      (zero)
    );

endmodule

// File: tb/tb_mod_down_counter_timer.sv
// Scoreboard bench for mod_down_counter_timer: a behavioural model predicts each cycle's outputs.
module tb_mod_down_counter_timer;

    localparam int BITS = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            enable;
    logic            start;
    logic            stop;
    logic            periodic;
    logic [BITS-1:0] FINAL_VALUE;
    logic [BITS-1:0] Q;
    logic            tick;
    logic            busy;

    int errors = 0;
    int checks = 0;
    int tick_count = 0;

    typedef struct {
        logic [BITS-1:0] q;
        logic            tick;
        logic            busy;
    } exp_t;

    exp_t sb[$];

    logic [BITS-1:0] m_q;
    logic            m_run;

    mod_down_counter_timer #(
        .BITS(BITS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .start      (start),
        .stop       (stop),
        .periodic   (periodic),
        .FINAL_VALUE(FINAL_VALUE),
        .Q          (Q),
        .tick       (tick),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, predict that cycle's outputs, compare, then advance the model on the edge.
    task automatic applyStimulus(input string tag, input logic en, input logic st, input logic sp,
                                 input logic per, input logic [BITS-1:0] fv);
        exp_t e;
        exp_t got;
        @(negedge clk);
        enable      = en;
        start       = st;
        stop        = sp;
        periodic    = per;
        FINAL_VALUE = fv;
        e.q    = m_q;
        e.busy = m_run;
        e.tick = m_run & en & (m_q == 0) & ~sp & ~st;
        sb.push_back(e);
        #1;
        got = sb.pop_front();
        checkOutput({tag, ".Q"}, 32'(Q), 32'(got.q));
        checkOutput({tag, ".tick"}, 32'(tick), 32'(got.tick));
        checkOutput({tag, ".busy"}, 32'(busy), 32'(got.busy));
        if (tick === 1'b1) tick_count++;
        @(posedge clk);
        if (sp) begin
            m_run = 1'b0;
            m_q   = '0;
        end else if (st) begin
            m_run = 1'b1;
            m_q   = fv;
        end else if (m_run && en) begin
            if (m_q == 0) begin
                if (per) m_q = fv;
                else     m_run = 1'b0;
            end else begin
                m_q = m_q - 1'b1;
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        periodic    = 1'b0;
        FINAL_VALUE = '0;
        m_q         = '0;
        m_run       = 1'b0;
        #2;
        checkOutput("reset.Q", 32'(Q), 32'd0);
        checkOutput("reset.busy", 32'(busy), 32'd0);
        checkOutput("reset.tick", 32'(tick), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 3; i++) applyStimulus("idle", 1'b1, 1'b0, 1'b0, 1'b0, 4'd3);

        // One-shot from 3: Q = 3, 2, 1, 0 with a single tick, then idle.
        tick_count = 0;
        applyStimulus("oneshot.start", 1'b1, 1'b1, 1'b0, 1'b0, 4'd3);
        for (int i = 0; i < 7; i++) applyStimulus("oneshot", 1'b1, 1'b0, 1'b0, 1'b0, 4'd3);
        checkOutput("oneshot.ticks", 32'(tick_count), 32'd1);

        // Periodic from 15, then FINAL_VALUE shrinks to 2 mid-count.
        tick_count = 0;
        applyStimulus("per15.start", 1'b1, 1'b1, 1'b0, 1'b1, 4'd15);
        for (int i = 0; i < 32; i++) applyStimulus("per15", 1'b1, 1'b0, 1'b0, 1'b1, 4'd15);
        checkOutput("per15.ticks", 32'(tick_count), 32'd2);
        for (int i = 0; i < 8; i++) applyStimulus("per15", 1'b1, 1'b0, 1'b0, 1'b1, 4'd15);
        for (int i = 0; i < 16; i++) applyStimulus("per2", 1'b1, 1'b0, 1'b0, 1'b1, 4'd2);

        // Enable toggling 1010...: tick after 5 enabled cycles.
        tick_count = 0;
        applyStimulus("gate.start", 1'b0, 1'b1, 1'b0, 1'b0, 4'd4);
        for (int i = 0; i < 12; i++) applyStimulus("gate", (i % 2 == 0), 1'b0, 1'b0, 1'b0, 4'd4);
        checkOutput("gate.ticks", 32'(tick_count), 32'd1);

        // Collisions: restart at Q = 0, stop at Q = 0, stop with start together.
        applyStimulus("coll.start", 1'b1, 1'b1, 1'b0, 1'b1, 4'd1);
        applyStimulus("coll.dec", 1'b1, 1'b0, 1'b0, 1'b1, 4'd1);
        applyStimulus("coll.restart0", 1'b1, 1'b1, 1'b0, 1'b1, 4'd2);
        applyStimulus("coll.dec", 1'b1, 1'b0, 1'b0, 1'b1, 4'd2);
        applyStimulus("coll.dec", 1'b1, 1'b0, 1'b0, 1'b1, 4'd2);
        applyStimulus("coll.stop0", 1'b1, 1'b0, 1'b1, 1'b1, 4'd2);
        applyStimulus("coll.idle", 1'b1, 1'b0, 1'b0, 1'b1, 4'd2);
        applyStimulus("coll.start5", 1'b1, 1'b1, 1'b0, 1'b0, 4'd5);
        applyStimulus("coll.run", 1'b1, 1'b0, 1'b0, 1'b0, 4'd5);
        applyStimulus("coll.stopstart", 1'b1, 1'b1, 1'b1, 1'b0, 4'd5);
        applyStimulus("coll.after", 1'b1, 1'b0, 1'b0, 1'b0, 4'd5);
        checkOutput("coll.Q", 32'(Q), 32'd0);
        checkOutput("coll.busy", 32'(busy), 32'd0);

        // FINAL_VALUE = 0 periodic: tick every enabled cycle.
        tick_count = 0;
        applyStimulus("fv0.start", 1'b1, 1'b1, 1'b0, 1'b1, 4'd0);
        for (int i = 0; i < 6; i++) applyStimulus("fv0", 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        checkOutput("fv0.ticks", 32'(tick_count), 32'd6);
        applyStimulus("fv0.stop", 1'b1, 1'b0, 1'b1, 1'b1, 4'd0);

        // Asynchronous reset mid-count at Q = 5.
        applyStimulus("areset.start", 1'b1, 1'b1, 1'b0, 1'b0, 4'd9);
        for (int i = 0; i < 4; i++) applyStimulus("areset.run", 1'b1, 1'b0, 1'b0, 1'b0, 4'd9);
        @(negedge clk);
        #1;
        checkOutput("areset.pre.Q", 32'(Q), 32'd5);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("areset.Q", 32'(Q), 32'd0);
        checkOutput("areset.busy", 32'(busy), 32'd0);
        checkOutput("areset.tick", 32'(tick), 32'd0);
        m_q   = '0;
        m_run = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus("areset.idle", 1'b1, 1'b0, 1'b0, 1'b0, 4'd9);
        applyStimulus("areset.restart", 1'b1, 1'b1, 1'b0, 1'b0, 4'd2);
        for (int i = 0; i < 4; i++) applyStimulus("areset.after", 1'b1, 1'b0, 1'b0, 1'b0, 4'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
